mul_share_sched: RTL and testbench

//  Scheduler sharing one repeated-addition multiplier datapath (A/B/P regs, B-decrement,
//  eqz flag) among NREQ requesters. Round-robin grants one requester at a time, drives
//  the datapath load/clear/add/decrement strobes, and returns the product with a one-cycle

---
 rtl/mul_share_sched.sv | 175 +++++++++++++++++
 tb/tb_mul_share_sched.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_sched.sv
// rtl/mul_share_sched.sv - round-robin scheduler sharing one repeated-addition multiplier datapath
//
// One owner at a time drives an external A/B/P datapath. The owner's operands are
// loaded into A and B, P is cleared, and P <= P + A with B <= B - 1 repeats until
// the datapath reports B == 0. The product is returned with a one-cycle done pulse.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   req       per-requester request, held until that requester's done pulse
//   opa/opb   packed operands, requester i at [i*WIDTH +: WIDTH]
//   grant     one-hot owner of the datapath, 0 when idle
//   done      one-hot one-cycle completion pulse to the owner
//   result    product, valid with done, held until the next done
//   busy      high while an operation owns the datapath
//   data_out  operand bus to the datapath
//   lda/ldb   load A / load B from data_out
//   clrp      clear P
//   ldp       P <= P + A
//   decb      B <= B - 1
//   eqz       datapath flag, B == 0
//   prod      datapath P register

module mul_share_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   opa,
    input  logic [NREQ*WIDTH-1:0]   opb,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         done,
    output logic [WIDTH-1:0]        result,
    output logic                    busy,
    output logic [WIDTH-1:0]        data_out,
    output logic                    lda,
    output logic                    ldb,
    output logic                    clrp,
    output logic                    ldp,
    output logic                    decb,
    input  logic                    eqz,
    input  logic [WIDTH-1:0]        prod
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE_HOT_0 = NREQ'(1);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_ADD,
        S_DONE
    } state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand_idx;
    logic            pick_valid;
    int              cand;

    logic [WIDTH-1:0] opa_arr [NREQ];
    logic [WIDTH-1:0] opb_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign opa_arr[i] = opa[i*WIDTH +: WIDTH];
        assign opb_arr[i] = opb[i*WIDTH +: WIDTH];
    end

    // Round-robin pick: scan from the farthest candidate back to rr_ptr so the
    // nearest set request (searching upward with wrap) is the last one written.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IW'(cand);
            if (req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Control FSM with registered grant/done/result/busy and the rr pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            grant  <= '0;
            done   <= '0;
            result <= '0;
            busy   <= 1'b0;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= '0;
                    if (pick_valid) begin
                        owner <= pick_idx;
                        grant <= ONE_HOT_0 << pick_idx;
                        busy  <= 1'b1;
                        state <= S_LOAD_A;
                    end else begin
                        grant <= '0;
                    end
                end
                S_LOAD_A: state <= S_LOAD_B;
                S_LOAD_B: state <= S_ADD;
                S_ADD: begin
                    // With eqz high no add happens this cycle, so prod is final
                    // and can be captured here to be valid alongside done.
                    if (eqz) begin
                        result <= prod;
                        done   <= ONE_HOT_0 << owner;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done   <= '0;
                    grant  <= '0;
                    busy   <= 1'b0;
                    rr_ptr <= (owner == LAST_IDX) ? '0 : owner + IW'(1);
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    grant <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath strobes and operand bus decode from state and owner only, so an
    // asynchronous reset clears them without waiting for a clock edge.
    always_comb begin
        data_out = '0;
        lda      = 1'b0;
        ldb      = 1'b0;
        clrp     = 1'b0;
        ldp      = 1'b0;
        decb     = 1'b0;
        case (state)
            S_LOAD_A: begin
                data_out = opa_arr[owner];
                lda      = 1'b1;
            end
            S_LOAD_B: begin
                data_out = opb_arr[owner];
                ldb      = 1'b1;
                clrp     = 1'b1;
            end
            S_ADD: begin
                ldp  = ~eqz;
                decb = ~eqz;
            end
            default: begin
                data_out = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_share_sched.sv
// tb/tb_mul_share_sched.sv - self-checking bench for mul_share_sched with a behavioural datapath
module tb_mul_share_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req   = '0;
    logic [NREQ*WIDTH-1:0] opa   = '0;
    logic [NREQ*WIDTH-1:0] opb   = '0;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      result;
    logic                  busy;
    logic [WIDTH-1:0]      data_out;
    logic                  lda, ldb, clrp, ldp, decb;
    logic                  eqz;
    logic [WIDTH-1:0]      prod;

    logic [WIDTH-1:0] dp_a = '0;
    logic [WIDTH-1:0] dp_b = '0;
    logic [WIDTH-1:0] dp_p = '0;

    int checks   = 0;
    int errors   = 0;
    int viol     = 0;
    int rr_model = 0;

    always #5 clk = ~clk;

    mul_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .opa(opa), .opb(opb),
        .grant(grant), .done(done), .result(result), .busy(busy),
        .data_out(data_out), .lda(lda), .ldb(ldb), .clrp(clrp),
        .ldp(ldp), .decb(decb), .eqz(eqz), .prod(prod)
    );

    // External datapath: A, B, P registers with B == 0 flag.
    always @(posedge clk) begin
        if (lda) dp_a <= data_out;
        if (ldb) dp_b <= data_out;
        else if (decb) dp_b <= dp_b - 1'b1;
        if (clrp) dp_p <= '0;
        else if (ldp) dp_p <= dp_p + dp_a;
    end
    assign eqz  = (dp_b == '0);
    assign prod = dp_p;

    // Continuous protocol observations, tallied and judged in test_invariants.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!$onehot0(grant) || !$onehot0(done)) viol++;
            if (lda && ldb) viol++;
            if (grant == '0 && ({lda, ldb, clrp, ldp, decb} != 5'b0 || data_out != '0 || busy)) viol++;
            if (grant != '0 && !busy) viol++;
            if (done != '0 && done != grant) viol++;
        end
    end

    function automatic logic [WIDTH-1:0] get_a(input int i);
        return opa[i*WIDTH +: WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] get_b(input int i);
        return opb[i*WIDTH +: WIDTH];
    endfunction

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        opa[i*WIDTH +: WIDTH] = a;
        opb[i*WIDTH +: WIDTH] = b;
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] mask, input int from);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(from + k) % NREQ]) return (from + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        rr_model = 0;
    endtask

    // Waits for a grant, follows one operation to its done pulse and checks it.
    // Returns at the negedge of the done cycle with req[owner] dropped if asked.
    task automatic serve_one(input int exp_owner, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input bit drop, input string tag);
        int n;
        int adds;
        logic [WIDTH-1:0] exp_p;
        logic [NREQ-1:0]  exp_oh;
        exp_p  = a * b;
        exp_oh = NREQ'(1) << exp_owner;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == '0 && n < 200);
        checks++;
        if (grant !== exp_oh) begin
            errors++;
            $display("FAIL %s grant: got %b want %b", tag, grant, exp_oh);
        end
        checks++;
        if (!(lda === 1'b1 && ldb === 1'b0 && data_out === a)) begin
            errors++;
            $display("FAIL %s load_a: got lda=%b ldb=%b data=%0d want 1 0 %0d", tag, lda, ldb, data_out, a);
        end
        @(negedge clk);
        checks++;
        if (!(ldb === 1'b1 && clrp === 1'b1 && lda === 1'b0 && data_out === b)) begin
            errors++;
            $display("FAIL %s load_b: got ldb=%b clrp=%b lda=%b data=%0d want 1 1 0 %0d", tag, ldb, clrp, lda, data_out, b);
        end
        n    = 2;
        adds = 0;
        while (done === '0 && n < 300) begin
            @(negedge clk);
            n++;
            if (ldp === 1'b1 && decb === 1'b1) adds++;
        end
        checks++;
        if (done !== exp_oh) begin
            errors++;
            $display("FAIL %s done: got %b want %b", tag, done, exp_oh);
        end
        checks++;
        if (n != int'(b) + 4) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, n, int'(b) + 4);
        end
        checks++;
        if (adds != int'(b)) begin
            errors++;
            $display("FAIL %s add_cycles: got %0d want %0d", tag, adds, int'(b));
        end
        checks++;
        if (result !== exp_p) begin
            errors++;
            $display("FAIL %s result: got %0d want %0d", tag, result, exp_p);
        end
        if (drop) req[exp_owner] = 1'b0;
        rr_model = (exp_owner + 1) % NREQ;
    endtask

    // The cycle after DONE must be idle: no grant, no done, busy low.
    task automatic after_done(input string tag);
        @(negedge clk);
        checks++;
        if (done !== '0 || busy !== 1'b0 || grant !== '0) begin
            errors++;
            $display("FAIL %s idle_gap: got done=%b busy=%b grant=%b want 0 0 0", tag, done, busy, grant);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== '0 || done !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: got grant=%b done=%b busy=%b want 0", grant, done, busy);
        end
        checks++;
        if (result !== '0 || data_out !== '0 || {lda, ldb, clrp, ldp, decb} !== 5'b0) begin
            errors++;
            $display("FAIL reset_dp: got result=%0d data=%0d strobes=%b want 0", result, data_out, {lda, ldb, clrp, ldp, decb});
        end
        apply_reset();
    endtask

    task automatic test_basic();
        set_op(0, 16'd17, 16'd5);
        req[0] = 1'b1;
        serve_one(0, 16'd17, 16'd5, 1'b1, "t1_17x5");
        after_done("t1");
        set_op(1, 16'd9, 16'd0);
        req[1] = 1'b1;
        serve_one(1, 16'd9, 16'd0, 1'b1, "t2_9x0");
        after_done("t2");
    endtask

    task automatic test_alternate();
        apply_reset();
        set_op(0, 16'd3, 16'd2);
        set_op(2, 16'd4, 16'd3);
        req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) serve_one(0, 16'd3, 16'd2, 1'b0, "t3_alt");
            else            serve_one(2, 16'd4, 16'd3, 1'b0, "t3_alt");
            if (i == 3) req = '0;
            after_done("t3");
        end
    endtask

    task automatic test_rr_wrap();
        set_op(3, 16'd5, 16'd4);
        req = 4'b1000;
        serve_one(3, 16'd5, 16'd4, 1'b1, "t4_first");
        after_done("t4a");
        set_op(0, 16'd11, 16'd3);
        set_op(3, 16'd6, 16'd7);
        req = 4'b1001;
        serve_one(0, 16'd11, 16'd3, 1'b1, "t4_wrap0");
        after_done("t4b");
        serve_one(3, 16'd6, 16'd7, 1'b1, "t4_then3");
        after_done("t4c");
    endtask

    task automatic test_reset_mid();
        int n;
        set_op(0, 16'd100, 16'd50);
        req = 4'b0001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == '0 && n < 200);
        repeat (10) @(negedge clk);
        checks++;
        if (ldp !== 1'b1) begin
            errors++;
            $display("FAIL t5_in_add: got ldp=%b want 1", ldp);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== '0 || done !== '0 || busy !== 1'b0 || result !== '0 ||
            data_out !== '0 || {lda, ldb, clrp, ldp, decb} !== 5'b0) begin
            errors++;
            $display("FAIL t5_async_reset: got grant=%b busy=%b data=%0d strobes=%b want 0",
                     grant, busy, data_out, {lda, ldb, clrp, ldp, decb});
        end
        @(negedge clk);
        rst_n    = 1'b1;
        rr_model = 0;
        serve_one(0, 16'd100, 16'd50, 1'b1, "t5_restart");
        after_done("t5");
    endtask

    task automatic test_drop();
        int n;
        set_op(2, 16'd7, 16'd6);
        req = 4'b0100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == '0 && n < 200);
        @(negedge clk);
        @(negedge clk);
        req = '0;
        set_op(2, 16'd99, 16'd99);
        n = 0;
        while (done === '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 4'b0100) begin
            errors++;
            $display("FAIL t6_done: got %b want 0100", done);
        end
        checks++;
        if (result !== 16'd42) begin
            errors++;
            $display("FAIL t6_result: got %0d want 42", result);
        end
        rr_model = 3;
        after_done("t6");
    endtask

    task automatic test_random();
        int exp_owner;
        logic [NREQ-1:0] newbits;
        for (int it = 0; it < 40; it++) begin
            if (req == '0 && it < 24) begin
                newbits = NREQ'($urandom_range(1, (1 << NREQ) - 1));
                for (int i = 0; i < NREQ; i++)
                    if (newbits[i]) set_op(i, WIDTH'($urandom), WIDTH'($urandom_range(0, 12)));
                req = newbits;
            end
            if (req == '0) break;
            exp_owner = rr_pick(req, rr_model);
            serve_one(exp_owner, get_a(exp_owner), get_b(exp_owner), 1'b1, "rand");
            if (it < 24) begin
                newbits = NREQ'($urandom_range(0, (1 << NREQ) - 1)) & ~req;
                for (int i = 0; i < NREQ; i++)
                    if (newbits[i]) set_op(i, WIDTH'($urandom), WIDTH'($urandom_range(0, 12)));
                req = req | newbits;
            end
            after_done("rand");
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL invariants: got %0d violations want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alternate();
        test_rr_wrap();
        test_reset_mid();
        test_drop();
        test_random();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
